valu_seq: RTL
=============

Name: valu_seq

Overview:
- Sequencer for the combinational vALU (128-bit reg_in1/reg_in2/reg_scalar_in, 3-bit valu_op, 8-bit SEW).
- Accepts one vector ALU instruction at a time over a valid/ready handshake.
- Steps the instruction through an LMUL register group, one 128-bit register per cycle: reads operands from the vector register file (VRF), drives vALU, registers the result and writes it back.
- Rejects illegal SEW and misaligned register groups with an error pulse.

Parameters:
VLEN, 128, vector register / vALU data width
NREG, 32, number of VRF registers
AW, 5, VRF address width (log2 NREG)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept
instr_op  in  3  valu_op to apply
instr_sew  in  8  element width: 8/16/32/64/128
instr_lmul  in  2  group size: 0=1, 1=2, 2=4, 3=8 registers
instr_vd  in  AW  destination group base
instr_vs1  in  AW  source-1 group base
instr_vs2  in  AW  source-2 group base
instr_scalar  in  VLEN  scalar operand for vALU
vrf_raddr1  out  AW  VRF read address, port 1 (combinational read)
vrf_raddr2  out  AW  VRF read address, port 2
vrf_rdata1  in  VLEN  VRF read data, port 1
vrf_rdata2  in  VLEN  VRF read data, port 2
vrf_we  out  1  VRF write enable, committed at clk edge
vrf_waddr  out  AW  VRF write address
vrf_wdata  out  VLEN  VRF write data
alu_in1  out  VLEN  to vALU reg_in1
alu_in2  out  VLEN  to vALU reg_in2
alu_op  out  3  to vALU valu_op
alu_sew  out  8  to vALU SEW
alu_scalar  out  VLEN  to vALU reg_scalar_in
alu_result  in  VLEN  from vALU reg_dest
busy  out  1  instruction in flight
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse (always coincident with done)

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, idx=0, latched op=0, sew=8, lmul=0, bases=0, scalar=0, wb regs=0. Outputs: vrf_we=0, done=0, err=0, busy=0, instr_ready=1.
- States: IDLE, EXEC, FLUSH, ERR.
- instr_ready=1 in IDLE, FLUSH and ERR; 0 in EXEC. Accept = instr_valid & instr_ready; all instr_* fields are latched on the accept edge.
- Legality is checked at accept. The instruction is illegal if:
  - sew is not in {8,16,32,64,128}, or
  - any of vd, vs1, vs2 is not a multiple of N = 1<<lmul.
- Accept transitions: legal -> EXEC with idx=0; illegal -> ERR.
- ERR: lasts one cycle; done=1, err=1, no VRF write. Then IDLE, or EXEC/ERR if a new accept occurs in that cycle.
- EXEC, per cycle:
  - vrf_raddr1=vs1+idx, vrf_raddr2=vs2+idx.
  - alu_in1=vrf_rdata1, alu_in2=vrf_rdata2; alu_op/alu_sew/alu_scalar come from latched registers.
  - At the edge: wb_data<=alu_result, wb_addr<=vd+idx, wb_valid<=1, idx++.
  - When idx==N-1 the next state is FLUSH.
- vrf_we=wb_valid, vrf_waddr=wb_addr, vrf_wdata=wb_data, all registered. The write for element i is presented in the cycle after its read.
- FLUSH: presents the last write with done=1. Then IDLE, or EXEC/ERR on a same-cycle accept. wb_valid clears unless EXEC continues.
- Outside EXEC, raddr/alu outputs keep their pass-through of latched values and are don't-care to consumers.
- busy=1 in EXEC and FLUSH.
- Latency: a legal instruction accepted at edge t0 writes reg i during cycle t0+1+i+1. done is in cycle t0+N+1. Back-to-back throughput is N+1 cycles per instruction.
- Hazards:
  - Aligned groups are either identical or disjoint, so an in-group RAW is impossible.
  - A new instruction accepted in FLUSH first reads one cycle after the previous last write commits. No forwarding is needed.
- Register indices never exceed NREG-1, because alignment guarantees it.
- Reset mid-operation: state returns to IDLE immediately (asynchronous). vrf_we, done and busy drop at once, and the in-flight instruction is discarded. Writes already committed stay in the VRF.

Test Plan:
- Reset: assert rst_n=0 at any state -> instr_ready=1, busy=0, vrf_we=0, done=0, err=0, alu_sew=8, all within the reset cycle.
- Single-register op: op=0, sew=8, lmul=0, vs1=2, vs2=3, vd=4; VRF[2]=f840_00AA_8000_0000_4840_00AA_8000_0000, VRF[3]=f448_00D5_0000_0000_4448_00D5_0000_0000. Expected: cycle 1 raddr1/2=2/3; cycle 2 vrf_we=1, waddr=4, wdata=model vALU result, done=1; cycle 3 idle.
- Group of 4: lmul=2, vs1=0, vs2=4, vd=8, sew=32. Expected: writes to 8,9,10,11 in cycles 2..5; done only in cycle 5; instr_ready=0 in cycles 1..4.
- Back-to-back: second instruction (vs1=8, the first's vd) held valid during the first's FLUSH. Expected: accepted in FLUSH; its first read sees the committed data; no idle bubble between them.
- Illegal: sew=12 -> exactly one cycle with err=1 and done=1, vrf_we never asserted. Same for lmul=1 with vd=3.
- Reset mid-group: lmul=3, deassert rst_n after 3 writes. Expected: vrf_we=0 immediately; only regs vd..vd+2 modified; after release instr_ready=1 and the next instruction runs normally.

Source files
------------

// File: rtl/valu_seq.sv
// Vector ALU sequencer: accepts one instruction at a time and steps it through
// an LMUL register group, one VRF register per cycle, with registered write-back.
module valu_seq #(
   parameter int VLEN = 128,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [2:0]      instr_op,
   input  logic [7:0]      instr_sew,
   input  logic [1:0]      instr_lmul,
   input  logic [AW-1:0]   instr_vd,
   input  logic [AW-1:0]   instr_vs1,
   input  logic [AW-1:0]   instr_vs2,
   input  logic [VLEN-1:0] instr_scalar,
   output logic [AW-1:0]   vrf_raddr1,
   output logic [AW-1:0]   vrf_raddr2,
   input  logic [VLEN-1:0] vrf_rdata1,
   input  logic [VLEN-1:0] vrf_rdata2,
   output logic            vrf_we,
   output logic [AW-1:0]   vrf_waddr,
   output logic [VLEN-1:0] vrf_wdata,
   output logic [VLEN-1:0] alu_in1,
   output logic [VLEN-1:0] alu_in2,
   output logic [2:0]      alu_op,
   output logic [7:0]      alu_sew,
   output logic [VLEN-1:0] alu_scalar,
   input  logic [VLEN-1:0] alu_result,
   output logic            busy,
   output logic            done,
   output logic            err
);

   // state | meaning
   // IDLE  | waiting for an instruction
   // EXEC  | reading/computing group element r_idx
   // FLUSH | last write-back presented, done pulse, may accept next
   // ERR   | illegal instruction rejected, done+err pulse, may accept next
   typedef enum logic [1:0] {IDLE, EXEC, FLUSH, ERR} state_t;

   state_t          r_state;
   logic [2:0]      r_idx;
   logic [2:0]      r_op;
   logic [7:0]      r_sew;
   logic [1:0]      r_lmul;
   logic [AW-1:0]   r_vd;
   logic [AW-1:0]   r_vs1;
   logic [AW-1:0]   r_vs2;
   logic [VLEN-1:0] r_scalar;
   logic            r_wb_valid;
   logic [AW-1:0]   r_wb_addr;
   logic [VLEN-1:0] r_wb_data;

   logic            w_accept;
   logic            w_sew_ok;
   logic            w_align_ok;
   logic            w_fits;
   logic            w_legal;
   logic [2:0]      w_mask_in;
   logic [2:0]      w_last_idx;
   logic [AW-1:0]   w_idx_ext;

   function automatic logic [2:0] grp_mask(input logic [1:0] lmul);
      case (lmul)
         2'd0:    grp_mask = 3'd0;
         2'd1:    grp_mask = 3'd1;
         2'd2:    grp_mask = 3'd3;
         default: grp_mask = 3'd7;
      endcase
   endfunction

   assign w_accept   = instr_valid & instr_ready;
   assign w_mask_in  = grp_mask(instr_lmul);
   assign w_last_idx = grp_mask(r_lmul);
   assign w_idx_ext  = {{(AW-3){1'b0}}, r_idx};

   assign w_sew_ok   = (instr_sew == 8'd8)  || (instr_sew == 8'd16) ||
                       (instr_sew == 8'd32) || (instr_sew == 8'd64) ||
                       (instr_sew == 8'd128);
   assign w_align_ok = ((instr_vd[2:0] | instr_vs1[2:0] | instr_vs2[2:0]) & w_mask_in) == 3'd0;
   // Aligned groups always fit a power-of-two register file; kept as a guard for odd NREG.
   assign w_fits     = (int'(instr_vd)  + int'(w_mask_in) < NREG) &&
                       (int'(instr_vs1) + int'(w_mask_in) < NREG) &&
                       (int'(instr_vs2) + int'(w_mask_in) < NREG);
   assign w_legal    = w_sew_ok & w_align_ok & w_fits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_idx      <= 3'd0;
         r_op       <= 3'd0;
         r_sew      <= 8'd8;
         r_lmul     <= 2'd0;
         r_vd       <= '0;
         r_vs1      <= '0;
         r_vs2      <= '0;
         r_scalar   <= '0;
         r_wb_valid <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_data  <= '0;
      end else begin
         if (r_state == EXEC) begin
            r_wb_data  <= alu_result;
            r_wb_addr  <= r_vd + w_idx_ext;
            r_wb_valid <= 1'b1;
            r_idx      <= r_idx + 3'd1;
            if (r_idx == w_last_idx) r_state <= FLUSH;
         end else begin
            // The next instruction's first write is at least one cycle away.
            r_wb_valid <= 1'b0;
            if (w_accept) begin
               r_op     <= instr_op;
               r_sew    <= instr_sew;
               r_lmul   <= instr_lmul;
               r_vd     <= instr_vd;
               r_vs1    <= instr_vs1;
               r_vs2    <= instr_vs2;
               r_scalar <= instr_scalar;
               r_idx    <= 3'd0;
               r_state  <= w_legal ? EXEC : ERR;
            end else begin
               r_state  <= IDLE;
            end
         end
      end
   end

   assign instr_ready = (r_state != EXEC);
   assign busy        = (r_state == EXEC) || (r_state == FLUSH);
   assign done        = (r_state == FLUSH) || (r_state == ERR);
   assign err         = (r_state == ERR);

   assign vrf_raddr1  = r_vs1 + w_idx_ext;
   assign vrf_raddr2  = r_vs2 + w_idx_ext;
   assign vrf_we      = r_wb_valid;
   assign vrf_waddr   = r_wb_addr;
   assign vrf_wdata   = r_wb_data;

   assign alu_in1     = vrf_rdata1;
   assign alu_in2     = vrf_rdata2;
   assign alu_op      = r_op;
   assign alu_sew     = r_sew;
   assign alu_scalar  = r_scalar;

endmodule
